// File: rtl/rv_lsu_pkg.sv
// Shared constants, request record and decode helpers for the load/store unit.
package rv_lsu_pkg;

    localparam int XLEN       = 32;
    localparam int DMEM_A_BIT = 12;

    localparam logic [2:0] DMEM_BYTECTRL_BYTE  = 3'b000;
    localparam logic [2:0] DMEM_BYTECTRL_HALF  = 3'b001;
    localparam logic [2:0] DMEM_BYTECTRL_WORD  = 3'b010;
    localparam logic [2:0] DMEM_BYTECTRL_BYTEU = 3'b100;
    localparam logic [2:0] DMEM_BYTECTRL_HALFU = 3'b101;

    localparam logic [1:0] LSU_IDLE   = 2'd0;
    localparam logic [1:0] LSU_ACCESS = 2'd1;
    localparam logic [1:0] LSU_RESP   = 2'd2;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] wd;
    } lsu_req_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 inside {DMEM_BYTECTRL_BYTE, DMEM_BYTECTRL_HALF, DMEM_BYTECTRL_WORD};
        return f3 inside {DMEM_BYTECTRL_BYTE, DMEM_BYTECTRL_HALF, DMEM_BYTECTRL_WORD,
                          DMEM_BYTECTRL_BYTEU, DMEM_BYTECTRL_HALFU};
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Request/response port between the pipeline and the LSU, and the LSU-to-memory port.
interface rv_lsu_req_if import rv_lsu_pkg::*;;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wd;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rd;
    logic            rsp_err;

    modport master (output req_valid, req_we, req_funct3, req_addr, req_wd,
                    input  req_ready, rsp_valid, rsp_rd, rsp_err);
    modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wd,
                    output req_ready, rsp_valid, rsp_rd, rsp_err);
endinterface

interface rv_dmem_if import rv_lsu_pkg::*; #(parameter int A_BIT = DMEM_A_BIT);
    logic [A_BIT-1:0] a;
    logic [XLEN-1:0]  wd;
    logic             we;
    logic [2:0]       bytectrl;
    logic [XLEN-1:0]  rd;

    modport master (output a, wd, we, bytectrl, input rd);
    modport slave  (input a, wd, we, bytectrl, output rd);
endinterface

// File: rtl/rv_lsu_extend.sv
// Sign/zero extension of the assembled load buffer according to funct3.
module rv_lsu_extend import rv_lsu_pkg::*; (
    input  logic [XLEN-1:0] buffer,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [2:0] f3);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        sb = v[7:0];
        sh = v[15:0];
        case (f3)
            DMEM_BYTECTRL_BYTE:  extend = XLEN'(sb);
            DMEM_BYTECTRL_HALF:  extend = XLEN'(sh);
            DMEM_BYTECTRL_BYTEU: extend = XLEN'(v[7:0]);
            DMEM_BYTECTRL_HALFU: extend = XLEN'(v[15:0]);
            default:             extend = v;
        endcase
    endfunction

    assign result = extend(buffer, funct3);

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one request, issues one aligned or several byte accesses, returns one response.
module rv_lsu import rv_lsu_pkg::*; #(
    parameter int A_BIT       = DMEM_A_BIT,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic      i_lsu_clk,
    input  logic      i_lsu_rst,
    rv_lsu_req_if.slave lsu,
    rv_dmem_if.master   dmem
);

    logic [1:0]       state;
    logic [1:0]       cnt;
    logic [1:0]       last;
    lsu_req_t         req;
    logic [A_BIT-1:0] addr;
    logic             split;
    logic             err;
    logic [XLEN-1:0]  buffer;
    logic [XLEN-1:0]  ext_rd;
    logic             accept;
    logic             misaligned;
    logic             reject;
    logic             unused_addr_hi;

    assign lsu.req_ready  = (state == LSU_IDLE) & ~i_lsu_rst;
    assign accept         = lsu.req_valid & lsu.req_ready;
    assign misaligned     = f3_misaligned(lsu.req_funct3, lsu.req_addr[1:0]);
    assign reject         = ~f3_legal(lsu.req_we, lsu.req_funct3) | (misaligned & ~MISALIGN_EN);
    assign unused_addr_hi = ^lsu.req_addr[XLEN-1:A_BIT];

    always_ff @(posedge i_lsu_clk or posedge i_lsu_rst) begin
        if (i_lsu_rst) begin
            state  <= LSU_IDLE;
            cnt    <= 2'd0;
            last   <= 2'd0;
            req    <= '0;
            addr   <= '0;
            split  <= 1'b0;
            err    <= 1'b0;
            buffer <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        req    <= '{we: lsu.req_we, funct3: lsu.req_funct3, wd: lsu.req_wd};
                        addr   <= lsu.req_addr[A_BIT-1:0];
                        split  <= misaligned;
                        err    <= reject;
                        cnt    <= 2'd0;
                        buffer <= '0;
                        // Word splits take four byte accesses, halfword splits two.
                        last   <= ~misaligned ? 2'd0 : (lsu.req_funct3[1] ? 2'd3 : 2'd1);
                        state  <= reject ? LSU_RESP : LSU_ACCESS;
                    end
                end
                LSU_ACCESS: begin
                    if (!req.we) begin
                        if (split)
                            buffer[{cnt, 3'b000} +: 8] <= dmem.rd[7:0];
                        else
                            buffer <= dmem.rd;
                    end
                    if (cnt == last)
                        state <= LSU_RESP;
                    else
                        cnt <= cnt + 2'd1;
                end
                LSU_RESP: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

    always_comb begin
        dmem.a        = '0;
        dmem.wd       = '0;
        dmem.we       = 1'b0;
        dmem.bytectrl = DMEM_BYTECTRL_BYTE;
        if (state == LSU_ACCESS) begin
            dmem.we = req.we;
            if (split) begin
                dmem.a        = addr + A_BIT'(cnt);
                dmem.wd       = req.wd >> {cnt, 3'b000};
                dmem.bytectrl = req.we ? DMEM_BYTECTRL_BYTE : DMEM_BYTECTRL_BYTEU;
            end else begin
                dmem.a        = addr;
                dmem.wd       = req.wd;
                dmem.bytectrl = req.funct3;
            end
        end
    end

    rv_lsu_extend u_extend (
        .buffer (buffer),
        .funct3 (req.funct3),
        .result (ext_rd)
    );

    assign lsu.rsp_valid = (state == LSU_RESP);
    assign lsu.rsp_err   = lsu.rsp_valid & err;
    assign lsu.rsp_rd    = (lsu.rsp_valid & ~err & ~req.we) ? ext_rd : '0;

endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu: byte-array memory model, directed requests, decoupled response monitors.
module tb_rv_lsu;
    import rv_lsu_pkg::*;

    localparam int AB = 12;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    logic [7:0]    mem [0:(1<<AB)-1];
    logic [AB-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [31:0]   w1, w2;

    rv_lsu_req_if r1();
    rv_lsu_req_if r2();
    rv_dmem_if #(.A_BIT(AB)) d1();
    rv_dmem_if #(.A_BIT(AB)) d2();

    rv_lsu #(.A_BIT(AB), .MISALIGN_EN(1'b1)) u_lsu (
        .i_lsu_clk (clk),
        .i_lsu_rst (rst),
        .lsu       (r1),
        .dmem      (d1)
    );

    rv_lsu #(.A_BIT(AB), .MISALIGN_EN(1'b0)) u_lsu_strict (
        .i_lsu_clk (clk),
        .i_lsu_rst (rst),
        .lsu       (r2),
        .dmem      (d2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_ext(input logic [31:0] w, input logic [2:0] bc);
        case (bc)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @* begin
        a0 = d1.a; a1 = d1.a + 1'b1; a2 = d1.a + 2'd2; a3 = d1.a + 2'd3;
        b0 = d2.a; b1 = d2.a + 1'b1; b2 = d2.a + 2'd2; b3 = d2.a + 2'd3;
        w1 = {mem[a3], mem[a2], mem[a1], mem[a0]};
        w2 = {mem[b3], mem[b2], mem[b1], mem[b0]};
        d1.rd = mem_ext(w1, d1.bytectrl);
        d2.rd = mem_ext(w2, d2.bytectrl);
    end

    always @(posedge clk) begin
        if (d1.we) begin
            mem[a0] <= d1.wd[7:0];
            if (d1.bytectrl[1:0] != 2'b00) mem[a1] <= d1.wd[15:8];
            if (d1.bytectrl[1]) begin
                mem[a2] <= d1.wd[23:16];
                mem[a3] <= d1.wd[31:24];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (r1.rsp_valid) begin
            if (q1.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("rsp_rd", r1.rsp_rd, e1.rd);
                chk("rsp_err", {31'd0, r1.rsp_err}, {31'd0, e1.err});
                chk("rsp_cycle", cyc, e1.due);
            end
        end
    end

    always @(negedge clk) begin
        if (r2.rsp_valid) begin
            if (q2.size() == 0) chk("unexpected_rsp2", 32'd1, 32'd0);
            else begin
                e2 = q2.pop_front();
                chk("rsp2_rd", r2.rsp_rd, e2.rd);
                chk("rsp2_err", {31'd0, r2.rsp_err}, {31'd0, e2.err});
                chk("rsp2_cycle", cyc, e2.due);
            end
        end
    end

    // n = number of memory accesses expected (0 for an error response); abort_k >= 0 resets during access k.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int n, input logic [2:0] bc,
                         input logic [31:0] exp_rd, input logic exp_err, input int abort_k);
        int w;
        logic [AB-1:0] ea;
        @(negedge clk);
        r1.req_valid = 1'b1; r1.req_we = we; r1.req_funct3 = f3;
        r1.req_addr = addr; r1.req_wd = wd;
        w = 0;
        while (!r1.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!r1.req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            r1.req_valid = 1'b0;
            return;
        end
        if (abort_k < 0) q1.push_back('{rd: exp_rd, err: exp_err, due: cyc + 1 + n});
        @(posedge clk);
        #1 r1.req_valid = 1'b0;
        r1.req_addr = 32'hFFFF_FFFF; r1.req_wd = 32'h0BAD_0BAD;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                chk("abort_we", {31'd0, d1.we}, 32'd0);
                chk("abort_a", {20'd0, d1.a}, 32'd0);
                return;
            end
            ea = (n > 1) ? AB'(addr + k) : AB'(addr);
            chk("acc_addr", {20'd0, d1.a}, {20'd0, ea});
            chk("acc_bytectrl", {29'd0, d1.bytectrl}, {29'd0, bc});
            chk("acc_we", {31'd0, d1.we}, {31'd0, we});
            if (we) chk("acc_wd", d1.wd, (n > 1) ? (wd >> (8 * k)) : wd);
        end
        if (n == 0) begin
            @(negedge clk);
            chk("err_no_we", {31'd0, d1.we}, 32'd0);
        end
    endtask

    task automatic issue2(input logic [2:0] f3, input logic [31:0] addr, input int n,
                          input logic [31:0] exp_rd, input logic exp_err);
        int w;
        @(negedge clk);
        r2.req_valid = 1'b1; r2.req_we = 1'b0; r2.req_funct3 = f3;
        r2.req_addr = addr; r2.req_wd = 32'h0;
        w = 0;
        while (!r2.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!r2.req_ready) begin
            chk("ready2_timeout", 32'd0, 32'd1);
            r2.req_valid = 1'b0;
            return;
        end
        q2.push_back('{rd: exp_rd, err: exp_err, due: cyc + 1 + n});
        @(posedge clk);
        #1 r2.req_valid = 1'b0;
        @(negedge clk);
        chk("strict_no_we", {31'd0, d2.we}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]} = 32'h44332211;
        {mem[7], mem[6], mem[5], mem[4]} = 32'h88776655;
        {mem[11], mem[10], mem[9], mem[8]} = 32'h000000AA;
        r1.req_valid = 1'b0; r1.req_we = 1'b0; r1.req_funct3 = 3'b000; r1.req_addr = '0; r1.req_wd = '0;
        r2.req_valid = 1'b0; r2.req_we = 1'b0; r2.req_funct3 = 3'b000; r2.req_addr = '0; r2.req_wd = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, r1.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, r1.rsp_valid}, 32'd0);
        chk("rst_we", {31'd0, d1.we}, 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", {31'd0, r1.req_ready}, 32'd1);

        issue(1'b0, 3'b010, 32'h0, 32'h0, 1, 3'b010, 32'h44332211, 1'b0, -1);
        issue(1'b0, 3'b010, 32'h2, 32'h0, 4, 3'b100, 32'h66554433, 1'b0, -1);
        issue(1'b0, 3'b001, 32'h7, 32'h0, 2, 3'b100, 32'hFFFFAA88, 1'b0, -1);
        issue(1'b0, 3'b101, 32'h7, 32'h0, 2, 3'b100, 32'h0000AA88, 1'b0, -1);
        issue(1'b0, 3'b000, 32'h7, 32'h0, 1, 3'b000, 32'hFFFFFF88, 1'b0, -1);
        issue(1'b0, 3'b100, 32'h1, 32'h0, 1, 3'b100, 32'h00000022, 1'b0, -1);
        issue(1'b0, 3'b001, 32'h2, 32'h0, 1, 3'b001, 32'h00004433, 1'b0, -1);
        issue(1'b0, 3'b010, 32'h4, 32'h0, 1, 3'b010, 32'h88776655, 1'b0, -1);
        issue(1'b1, 3'b010, 32'h5, 32'hDEADBEEF, 4, 3'b000, 32'h0, 1'b0, -1);
        issue(1'b0, 3'b010, 32'h4, 32'h0, 1, 3'b010, 32'hADBEEF55, 1'b0, -1);
        issue(1'b0, 3'b010, 32'h8, 32'h0, 1, 3'b010, 32'h000000DE, 1'b0, -1);
        issue(1'b1, 3'b001, 32'h10, 32'hCAFEBABE, 1, 3'b001, 32'h0, 1'b0, -1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1, 3'b010, 32'h0000BABE, 1'b0, -1);
        issue(1'b0, 3'b011, 32'h0, 32'h0, 0, 3'b000, 32'h0, 1'b1, -1);
        issue(1'b1, 3'b101, 32'h0, 32'h1234, 0, 3'b000, 32'h0, 1'b1, -1);

        issue2(3'b010, 32'h2, 0, 32'h0, 1'b1);
        issue2(3'b010, 32'h0, 1, 32'h44332211, 1'b0);

        issue(1'b1, 3'b010, 32'h5, 32'h11223344, 4, 3'b000, 32'h0, 1'b0, 2);
        chk("abort_ready_in_rst", {31'd0, r1.req_ready}, 32'd0);
        @(negedge clk);
        chk("abort_no_rsp", {31'd0, r1.rsp_valid}, 32'd0);
        rst = 1'b0;
        #1 chk("abort_ready_release", {31'd0, r1.req_ready}, 32'd1);
        issue(1'b0, 3'b010, 32'h4, 32'h0, 1, 3'b010, 32'hAD334455, 1'b0, -1);
        issue(1'b0, 3'b010, 32'h8, 32'h0, 1, 3'b010, 32'h000000DE, 1'b0, -1);

        repeat (5) @(negedge clk);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
